decode_stage: RTL
=================

# decode_stage

Registered, parametrised instruction-decode stage for the LEGv8 datapath, sitting between fetch and execute. It accepts one 32-bit instruction per cycle over a valid/ready handshake and produces a fully defined control word with register indices and an extended immediate one cycle later. It adds BL link-register write, MOVK shift handling, illegal-opcode flagging, a one-bubble load-use interlock, and saturating event counters.

## Interface
- `DATA_W`, default 64: width of the extended immediate.
- `REG_W`, default 5: width of a register index.
- `CNT_W`, default 16: width of each event counter.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: fetch presents `instruction`.
- `in_ready` out 1: stage accepts `instruction` this cycle.
- `instruction` in 32: raw LEGv8 encoding.
- `out_valid` out 1: decoded word valid.
- `out_ready` in 1: execute consumes the decoded word.
- `register1`, `register2`, `writeRegister` out REG_W: source and destination indices.
- `immediate` out DATA_W: extended immediate.
- `Reg2Loc`, `Uncondbranch`, `Branch`, `MemRead`, `MemtoReg`, `MemWrite`, `ALUSrc`, `RegWrite` out 1: datapath controls.
- `ALUOp` out 2: 00 add/address, 01 pass-B/compare, 10 funct-decoded.
- `Link` out 1: BL; writeback selects PC+4.
- `illegal` out 1: unrecognised opcode.
- `stall_count`, `illegal_count` out CNT_W: saturating event counters.

## Operation
- Decode uses prioritised match on the top bits:
  - B `000101`, BL `100101` [31:26]: immediate = sext([25:0]).
  - CBZ/CBNZ `1011010x` [31:24]: immediate = sext([23:5]); register2 = [4:0]; Reg2Loc = 1; Branch = 1; ALUOp = 01.
  - LDUR `11111000010`, STUR `11111000000` [31:21]: immediate = sext([20:12]); register1 = [9:5]; ALUSrc = 1; ALUOp = 00.
  - R-type ADD/SUB/AND/ORR [31:21]: register1 = [9:5]; register2 = [20:16]; writeRegister = [4:0]; RegWrite = 1; ALUOp = 10.
  - I-type ADDI/SUBI/ANDI/ORRI [31:22]: immediate = zext([21:10]); ALUSrc = 1; RegWrite = 1; ALUOp = 10.
  - MOVK `111100101` [31:23]: immediate = zext([20:5]) << (16 × [22:21]); MemtoReg = 1; RegWrite = 1.
- BL additionally sets RegWrite = 1, writeRegister = 30, Link = 1. B sets only Uncondbranch = 1.
- Any field not used by the decoded class is driven 0; every output is defined for every encoding (no latched state).
- Illegal encoding: all controls 0, `illegal` = 1, word still issued; `illegal_count` increments on acceptance.
- Load-use interlock: hazard = out_valid ∧ MemRead(out) ∧ writeRegister(out) ≠ 31 ∧ the incoming instruction reads that index through register1 (R, I, D, MOVK) or register2 (R, CB, STUR).
  - While hazard holds, in_ready = 0.
  - stall_count increments once per hazard cycle with in_valid = 1.
- Counters saturate at all-ones and do not wrap.

## Timing
- Latency: one cycle from accept (in_valid ∧ in_ready) to out_valid.
- in_ready = (¬out_valid ∨ out_ready) ∧ ¬hazard.
- Output register loads on accept.
- out_valid clears when out_ready = 1 and there is no accept.
- Outputs hold stable while out_valid ∧ ¬out_ready.
- A load consumed with a dependent pending yields exactly one cycle of out_valid = 0 (the bubble); the dependent is accepted in that cycle.
- Simultaneous consume and accept: the new word replaces the old with no gap.
- Reset: out_valid = 0, all controls, indices, immediate, Link, illegal = 0, both counters = 0. Reset mid-transfer discards the held word.

## Structure
- `decode_pkg` holds:
  - opcode constants and match masks;
  - ALUOp encodings;
  - a packed control-word typedef;
  - XZR index (31) and LR index (30).
- Sub-module `decode_comb`: purely combinational instruction → control word plus extended immediate. It is instantiated once for the incoming instruction; hazard source use comes from its outputs.
- `decode_stage` owns the handshake, output register, interlock and counters.

## Test plan
- Reset, then ADDI `0x91000C41` with out_ready = 1 → next cycle: out_valid = 1, ALUSrc = 1, immediate = 3, register1 = 2, writeRegister = 1, ALUOp = 10.
- LDUR X3,[X1,#0] followed by ADD X4,X3,X2 → in_ready = 0 for one cycle, one bubble, stall_count = 1; ADD issues next.
- Load to X31 followed by a reader of X31 → no stall; stall_count stays 0.
- BL with imm26 = all-ones → immediate = all-ones (−1), writeRegister = 30, RegWrite = 1, Link = 1.
- MOVK with hw = 3, imm16 = 0xBEEF → immediate = 0xBEEF_0000_0000_0000.
- Encoding `0x00000000` with out_ready held 0 for three cycles → illegal = 1, outputs stable, in_ready = 0, illegal_count = 1.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared LEGv8 decode definitions: opcode patterns, ALUOp codes and the
// packed control word carried from the decoder into the output register.
package decode_pkg;

    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    localparam logic [7:0]  CB_MATCH = 8'b10110100;
    localparam logic [7:0]  CB_MASK  = 8'b11111110;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
    localparam logic [9:0]  OP_ANDI  = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI  = 10'b1011001000;
    localparam logic [8:0]  OP_MOVK  = 9'b111100101;

    localparam logic [1:0]  ALU_ADD   = 2'b00;
    localparam logic [1:0]  ALU_PASSB = 2'b01;
    localparam logic [1:0]  ALU_FUNCT = 2'b10;

    localparam logic [4:0]  XZR_IDX = 5'd31;
    localparam logic [4:0]  LR_IDX  = 5'd30;

    typedef struct packed {
        logic       reg2loc;
        logic       uncondbranch;
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] aluop;
        logic       link;
        logic       illegal;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/decode_comb.sv
// Combinational LEGv8 decoder: instruction to control word, register indices,
// extended immediate and source-usage flags for the load-use interlock.
module decode_comb
    import decode_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
) (
    input  logic [31:0]       instruction,
    output logic [CTRL_W-1:0] ctrl,
    output logic [REG_W-1:0]  register1,
    output logic [REG_W-1:0]  register2,
    output logic [REG_W-1:0]  writeRegister,
    output logic [DATA_W-1:0] immediate,
    output logic              use1,
    output logic              use2
);

    ctrl_t       c;
    logic [10:0] op11;

    assign op11 = instruction[31:21];
    assign ctrl = c;

    always_comb begin
        c             = '0;
        register1     = '0;
        register2     = '0;
        writeRegister = '0;
        immediate     = '0;
        use1          = 1'b0;
        use2          = 1'b0;
        if (instruction[31:26] == OP_B || instruction[31:26] == OP_BL) begin
            c.uncondbranch = 1'b1;
            immediate      = DATA_W'($signed(instruction[25:0]));
            if (instruction[31:26] == OP_BL) begin
                c.regwrite    = 1'b1;
                c.link        = 1'b1;
                writeRegister = REG_W'(LR_IDX);
            end
        end else if ((instruction[31:24] & CB_MASK) == CB_MATCH) begin
            c.reg2loc = 1'b1;
            c.branch  = 1'b1;
            c.aluop   = ALU_PASSB;
            immediate = DATA_W'($signed(instruction[23:5]));
            register2 = REG_W'(instruction[4:0]);
            use2      = 1'b1;
        end else if (op11 == OP_LDUR || op11 == OP_STUR) begin
            c.alusrc  = 1'b1;
            c.aluop   = ALU_ADD;
            immediate = DATA_W'($signed(instruction[20:12]));
            register1 = REG_W'(instruction[9:5]);
            use1      = 1'b1;
            if (op11 == OP_LDUR) begin
                c.memread     = 1'b1;
                c.memtoreg    = 1'b1;
                c.regwrite    = 1'b1;
                writeRegister = REG_W'(instruction[4:0]);
            end else begin
                // the store data register is routed through register2
                c.memwrite = 1'b1;
                c.reg2loc  = 1'b1;
                register2  = REG_W'(instruction[4:0]);
                use2       = 1'b1;
            end
        end else if (op11 inside {OP_ADD, OP_SUB, OP_AND, OP_ORR}) begin
            c.regwrite    = 1'b1;
            c.aluop       = ALU_FUNCT;
            register1     = REG_W'(instruction[9:5]);
            register2     = REG_W'(instruction[20:16]);
            writeRegister = REG_W'(instruction[4:0]);
            use1          = 1'b1;
            use2          = 1'b1;
        end else if (instruction[31:22] inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI}) begin
            c.alusrc      = 1'b1;
            c.regwrite    = 1'b1;
            c.aluop       = ALU_FUNCT;
            immediate     = DATA_W'(instruction[21:10]);
            register1     = REG_W'(instruction[9:5]);
            writeRegister = REG_W'(instruction[4:0]);
            use1          = 1'b1;
        end else if (instruction[31:23] == OP_MOVK) begin
            // MOVK merges into Rd, so Rd is also its source operand
            c.memtoreg    = 1'b1;
            c.regwrite    = 1'b1;
            immediate     = DATA_W'(instruction[20:5]) << {instruction[22:21], 4'b0000};
            register1     = REG_W'(instruction[4:0]);
            writeRegister = REG_W'(instruction[4:0]);
            use1          = 1'b1;
        end else begin
            c.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered LEGv8 decode stage: valid/ready handshake, output register,
// one-bubble load-use interlock and saturating stall/illegal counters.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_W-1:0]  register1,
    output logic [REG_W-1:0]  register2,
    output logic [REG_W-1:0]  writeRegister,
    output logic [DATA_W-1:0] immediate,
    output logic              Reg2Loc,
    output logic              Uncondbranch,
    output logic              Branch,
    output logic              MemRead,
    output logic              MemtoReg,
    output logic              MemWrite,
    output logic              ALUSrc,
    output logic              RegWrite,
    output logic [1:0]        ALUOp,
    output logic              Link,
    output logic              illegal,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  illegal_count
);

    ctrl_t             dec_c;
    ctrl_t             q_c;
    logic [REG_W-1:0]  dec_r1, dec_r2, dec_wr;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_use1, dec_use2;
    logic              hazard, accept;

    decode_comb #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_dec (
        .instruction   (instruction),
        .ctrl          (dec_c),
        .register1     (dec_r1),
        .register2     (dec_r2),
        .writeRegister (dec_wr),
        .immediate     (dec_imm),
        .use1          (dec_use1),
        .use2          (dec_use2)
    );

    // A held load to a real register blocks any reader of that register until
    // the load has left; writes to XZR never create a dependency.
    assign hazard = out_valid && q_c.memread && (writeRegister != REG_W'(XZR_IDX)) &&
                    ((dec_use1 && dec_r1 == writeRegister) ||
                     (dec_use2 && dec_r2 == writeRegister));
    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            q_c           <= '0;
            register1     <= '0;
            register2     <= '0;
            writeRegister <= '0;
            immediate     <= '0;
            stall_count   <= '0;
            illegal_count <= '0;
        end else begin
            if (accept) begin
                out_valid     <= 1'b1;
                q_c           <= dec_c;
                register1     <= dec_r1;
                register2     <= dec_r2;
                writeRegister <= dec_wr;
                immediate     <= dec_imm;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (hazard && in_valid && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
            if (accept && dec_c.illegal && illegal_count != '1)
                illegal_count <= illegal_count + CNT_W'(1);
        end
    end

    assign Reg2Loc      = q_c.reg2loc;
    assign Uncondbranch = q_c.uncondbranch;
    assign Branch       = q_c.branch;
    assign MemRead      = q_c.memread;
    assign MemtoReg     = q_c.memtoreg;
    assign MemWrite     = q_c.memwrite;
    assign ALUSrc       = q_c.alusrc;
    assign RegWrite     = q_c.regwrite;
    assign ALUOp        = q_c.aluop;
    assign Link         = q_c.link;
    assign illegal      = q_c.illegal;

endmodule
